// File: rtl/eeprom_seq_ctrl.sv
// eeprom_seq_ctrl: walks generated address/data pairs through an I2C EEPROM engine,
// verifies read-back data and publishes each result to a hex display.
module eeprom_seq_ctrl #(
    parameter int         N_ENTRIES      = 4,
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter logic [7:0] ADDR_STEP      = 8'h10,
    parameter logic [7:0] DATA_SEED      = 8'hF5,
    parameter logic [7:0] DATA_STEP      = 8'h52,
    parameter int         HOLD_CYCLES    = 50_000_000,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         CNT_W          = 26
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [7:0]  rddata,
    input  logic        done_sig,
    output logic [1:0]  start_sig,
    output logic [7:0]  addr_sig,
    output logic [7:0]  wrdata,
    output logic [23:0] number_sig,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_HOLD, S_NEXT} state_t;

    localparam logic [7:0]       IDX_LAST  = 8'(N_ENTRIES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [7:0]       r_idx, r_addr, r_data, r_addr_sig, r_wrdata, r_err;
    logic [1:0]       r_start, r_mode;
    logic [23:0]      r_num;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic       w_wrap, w_rd_err;
    logic [7:0] w_nxt_addr, w_nxt_data, w_err_inc, w_err_rd;
    logic [1:0] w_mode;

    always_comb begin
        w_wrap     = r_idx == IDX_LAST;
        w_nxt_addr = w_wrap ? BASE_ADDR : r_addr + ADDR_STEP;
        w_nxt_data = w_wrap ? DATA_SEED : r_data + DATA_STEP;
        w_err_inc  = (&r_err) ? r_err : r_err + 8'd1;
        w_rd_err   = r_mode != 2'b01 && rddata != r_wrdata;
        w_err_rd   = w_rd_err ? w_err_inc : r_err;
        // mode 11 folds into the write-then-verify flow
        w_mode     = (mode == 2'b01 || mode == 2'b10) ? mode : 2'b00;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 8'd0;
            r_addr     <= BASE_ADDR;
            r_data     <= DATA_SEED;
            r_addr_sig <= 8'd0;
            r_wrdata   <= 8'd0;
            r_err      <= 8'd0;
            r_start    <= 2'b00;
            r_mode     <= 2'b00;
            r_num      <= 24'd0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (en) begin
                    r_mode     <= w_mode;
                    r_addr_sig <= r_addr;
                    r_wrdata   <= r_data;
                    r_state    <= (w_mode == 2'b01) ? S_RD : S_WR;
                    r_busy     <= 1'b1;
                    r_cnt      <= '0;
                end
                S_WR, S_RD: begin
                    if (r_start == 2'b00) begin
                        r_start <= (r_state == S_WR) ? 2'b01 : 2'b10;
                    end else if (done_sig) begin
                        r_start <= 2'b00;
                        r_cnt   <= '0;
                        if (r_state == S_WR && r_mode == 2'b00) begin
                            r_state <= S_RD;
                        end else if (r_state == S_WR) begin
                            r_state <= S_HOLD;
                            r_num   <= {r_err, r_addr_sig, r_wrdata};
                        end else begin
                            r_state <= S_HOLD;
                            r_err   <= w_err_rd;
                            r_num   <= {w_err_rd, r_addr_sig, rddata};
                        end
                    end else if (r_cnt == TMO_LAST) begin
                        r_start <= 2'b00;
                        r_cnt   <= '0;
                        r_err   <= w_err_inc;
                        r_num   <= {w_err_inc, r_addr_sig, 8'hEE};
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    r_idx  <= w_wrap ? 8'd0 : r_idx + 8'd1;
                    r_addr <= w_nxt_addr;
                    r_data <= w_nxt_data;
                    if (en) begin
                        r_mode     <= w_mode;
                        r_addr_sig <= w_nxt_addr;
                        r_wrdata   <= w_nxt_data;
                        r_state    <= (w_mode == 2'b01) ? S_RD : S_WR;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_sig  = r_start;
    assign addr_sig   = r_addr_sig;
    assign wrdata     = r_wrdata;
    assign number_sig = r_num;
    assign busy       = r_busy;
    assign err_cnt    = r_err;
endmodule
